wm_embed_ctrl: RTL and testbench
================================

# wm_embed_ctrl

Frame-level controller for the watermark path: owns the 8-bit watermark LFSR and sequences it against an incoming pixel stream. It reseeds the LFSR from the key at each frame start and advances it exactly once per accepted pixel. It replaces each pixel's two LSBs with the current 2-bit watermark symbol and counts pixels to frame end. It sits between the pixel source (frame reader) and the pixel sink (output writer / VGA buffer).

## Interface
- PIX_W, 8, pixel width in bits (≥ 3)
- N_PIXELS, 16384, pixels per frame (128×128); legal range 1 … 2^CNT_W−1
- CNT_W, 16, pixel counter width
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle frame start request; honoured only in IDLE
- key  in  8  LFSR seed, sampled in LOAD
- in_valid  in  1  source pixel valid
- in_data  in  PIX_W  source pixel
- in_ready  out  1  controller accepts pixel this cycle
- out_valid  out  1  watermarked pixel valid
- out_data  out  PIX_W  watermarked pixel
- out_ready  in  1  sink accepts pixel this cycle
- busy  out  1  high in LOAD, RUN, FLUSH
- done  out  1  one-cycle pulse on frame completion

## Operation
- State machine: IDLE → LOAD on start; LOAD → RUN unconditionally; RUN → FLUSH when the N_PIXELS-th pixel is accepted at input; FLUSH → DONE when the output register is empty or drains (out_valid & out_ready); DONE → IDLE unconditionally.
- LOAD: lfsr ← key, except key = 8'h00 loads 8'h01 (lock-up avoidance); pixel count ← 0.
- LFSR step (polynomial x^8+x^4+x^3+x^2+1, period 255): next = {q6, q5, q4, q3^q7, q2^q7, q1^q7, q0, q7}. It steps only on input accept (in_valid & in_ready); otherwise it holds.
- Symbol from the current (pre-step) state: wm[1] = q1^q0; wm[0] = wm[1] ? 0 : q0.
- Embed: out_data ← {in_data[PIX_W−1:2], wm}, registered on accept.
- in_ready = (state == RUN) & (count < N_PIXELS) & (~out_valid | out_ready). The single output register has no bubble under continuous flow.
- Pixel count increments on each accept. It never wraps within a frame.
- start outside IDLE is ignored. key changes outside LOAD have no effect.
- in_valid outside RUN is not accepted and causes no state change.
- Simultaneous accept and output drain in the same cycle: the register is reloaded with the new pixel and out_valid stays 1.

## Timing
- Reset (rst_n low, any state, asynchronous): state = IDLE, lfsr = 8'h01, count = 0, out_valid = 0, out_data = 0, in_ready = 0, busy = 0, done = 0.
- Mid-frame reset discards the in-flight pixel. There is no done pulse.
- start sampled high in IDLE at edge T: LOAD during T..T+1, RUN from T+1, first in_ready possible in cycle T+1..T+2.
- Latency: a pixel accepted at edge E has out_valid = 1 from E onward (1 cycle). It holds stable with out_data until out_ready.
- done is asserted in the cycle after the last output handshake (DONE state), for exactly 1 cycle. busy falls in the same cycle.
- A new start is accepted no earlier than the cycle after done.

## Test plan
- Reset/idle: drive rst_n low mid-RUN with out_valid = 1 → all outputs go to their reset values immediately. After release, in_valid = 1 gets no in_ready until start.
- Sequence check: key = 8'h6A, N_PIXELS = 4, in_data = 8'hFF ×4, out_ready = 1 → out_data = 8'hFE, 8'hFC, 8'hFE in order. The 4th value matches the model. done pulses once, 1 cycle after the 4th output.
- Zero key: key = 8'h00 → LFSR loads 8'h01. First symbol is 2'b10, so in_data 8'h00 → 8'h02. The stream never stalls at all-zero.
- Backpressure: out_ready low for 5 cycles mid-frame → in_ready = 0 and out_data held. The LFSR does not step. The output sequence is identical to the no-stall run.
- Source gaps: in_valid toggles 1/0 → the LFSR steps only on accepts. After 255 accepts the state returns to the seed.
- Start while busy: pulse start in RUN → ignored, count unaffected. A second frame after done with the same key reproduces the identical symbol sequence.

Source files
------------

// File: rtl/wm_embed_ctrl_if.sv
// Pixel stream bundle for the watermark embedder: source-side and sink-side
// valid/ready handshakes grouped into one interface.
interface wm_embed_ctrl_if #(
  parameter int PIX_W = 8
) ();
  logic             in_valid;
  logic [PIX_W-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [PIX_W-1:0] out_data;
  logic             out_ready;

  // master = source and sink side; slave = the embedding controller
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/wm_embed_ctrl.sv
// Frame controller for the watermark path: reseeds the 8-bit LFSR per frame,
// steps it once per accepted pixel and embeds the 2-bit symbol in the pixel LSBs.
module wm_embed_ctrl #(
  parameter int PIX_W    = 8,
  parameter int N_PIXELS = 16384,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      key,
  wm_embed_ctrl_if.slave  pix,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] N_TOTAL = CNT_W'(N_PIXELS);
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_PIXELS - 1);

  state_e           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;

  logic             accept;
  logic [1:0]       wm;
  logic [7:0]       lfsr_step;

  // Symbol comes from the pre-step state; the step is x^8+x^4+x^3+x^2+1.
  always_comb begin
    wm[1]     = lfsr_q[1] ^ lfsr_q[0];
    wm[0]     = wm[1] ? 1'b0 : lfsr_q[0];
    lfsr_step = {lfsr_q[6], lfsr_q[5], lfsr_q[4],
                 lfsr_q[3] ^ lfsr_q[7], lfsr_q[2] ^ lfsr_q[7], lfsr_q[1] ^ lfsr_q[7],
                 lfsr_q[0], lfsr_q[7]};
  end

  // Ready looks through a draining output register so continuous flow has no bubble.
  assign pix.in_ready  = (state_q == S_RUN) && (count_q < N_TOTAL) &&
                         (!out_valid_q || pix.out_ready);
  assign accept        = pix.in_valid && pix.in_ready;
  assign pix.out_valid = out_valid_q;
  assign pix.out_data  = out_data_q;
  assign busy          = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done          = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = {pix.in_data[PIX_W-1:2], wm};
      lfsr_d      = lfsr_step;
      count_d     = count_q + 1'b1;
    end else if (out_valid_q && pix.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        // an all-zero seed would lock the LFSR up
        lfsr_d  = (key == 8'h00) ? 8'h01 : key;
        count_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (accept && (count_q == N_LAST)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!out_valid_q || pix.out_ready) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= 8'h01;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_wm_embed_ctrl.sv
// Scoreboard bench for wm_embed_ctrl: random frames against a GF(2^8) power-sequence
// model, with fixed-pattern frames for the known sequence, zero key, stall and reset cases.
module tb_wm_embed_ctrl;
  localparam int PIX_W = 8;
  localparam int NPIX  = 260;
  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] key;
  logic       busy;
  logic       done;

  wm_embed_ctrl_if #(.PIX_W(PIX_W)) pif ();

  wm_embed_ctrl #(
    .PIX_W   (PIX_W),
    .N_PIXELS(NPIX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .key  (key),
    .pix  (pif.slave),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         out_cnt = 0;
  logic       expect_done = 1'b0;
  logic       done_seen = 1'b0;
  logic [7:0] out_log[NPIX];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Watermark state after k accepts is seed * x^k in GF(2^8) mod 0x11D.
  function automatic logic [7:0] mul_x(input logic [7:0] s);
    logic [8:0] t;
    t = {s, 1'b0};
    if (t[8]) t = t ^ 9'h11D;
    return t[7:0];
  endfunction

  function automatic logic [1:0] sym_of(input logic [7:0] s);
    case (s[1:0])
      2'b00:        return 2'b00;
      2'b01, 2'b10: return 2'b10;
      default:      return 2'b01;
    endcase
  endfunction

  task automatic checkOutput();
    logic [7:0] e;
    if (expect_done || done) begin
      check_val("done_pulse", 32'(done), 32'(expect_done));
      if (expect_done) check_val("busy_at_done", 32'(busy), 32'(0));
    end
    if (done) done_seen = 1'b1;
    expect_done = 1'b0;
    if (pif.out_valid && pif.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got %0h, expected no output", pif.out_data);
      end else begin
        e = exp_q.pop_front();
        check_val("out_data", 32'(pif.out_data), 32'(e));
      end
      if (out_cnt < NPIX) out_log[out_cnt] = pif.out_data;
      out_cnt++;
      if (out_cnt == NPIX) begin
        out_cnt     = 0;
        expect_done = 1'b1;
      end
    end
  endtask

  // Output monitor samples one time unit before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) checkOutput();
    end
  end

  task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic ordy,
                               input logic st, input logic [7:0] k, output logic acc);
    @(negedge clk);
    pif.in_valid  = iv;
    pif.in_data   = d;
    pif.out_ready = ordy;
    start         = st;
    key           = k;
    #4;
    acc = pif.in_valid && pif.in_ready;
  endtask

  task automatic run_frame(input logic [7:0] k, input int data_mode, input int valid_pct,
                           input int ready_pct, input bit do_stall, input bit do_start);
    logic       acc;
    logic       iv, ordy;
    logic [7:0] s, d, last_exp;
    int         accepted = 0;
    int         cycles = 0;
    bit         stalled = 0;
    done_seen = 1'b0;
    s         = (k == 8'h00) ? 8'h01 : k;
    last_exp  = 8'h00;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, k, acc);
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, k, acc);
    check_val("no_accept_in_load", 32'(pif.in_ready), 32'(0));
    acc = 1'b0;
    while (accepted < NPIX && cycles < 40 * NPIX) begin
      cycles++;
      if (do_stall && !stalled && accepted == 10 && acc) begin
        stalled = 1;
        for (int i = 0; i < 5; i++) begin
          applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 8'($urandom), acc);
          check_val("stall_in_ready", 32'(pif.in_ready), 32'(0));
          check_val("stall_out_valid", 32'(pif.out_valid), 32'(1));
          check_val("stall_out_data", 32'(pif.out_data), 32'(last_exp));
          check_val("stall_busy", 32'(busy), 32'(1));
        end
      end
      d    = (data_mode < 0) ? 8'($urandom) : 8'(data_mode);
      iv   = (int'($urandom_range(99)) < valid_pct);
      ordy = (int'($urandom_range(99)) < ready_pct);
      applyStimulus(iv, d, ordy, do_start && (accepted == 20), 8'($urandom), acc);
      if (acc) begin
        last_exp = {d[7:2], sym_of(s)};
        exp_q.push_back(last_exp);
        s = mul_x(s);
        accepted++;
      end
    end
    check_val("frame_accepts", 32'(accepted), 32'(NPIX));
    cycles = 0;
    while (!done_seen && cycles < 400) begin
      cycles++;
      ordy = (int'($urandom_range(99)) < ready_pct);
      applyStimulus(1'b1, 8'($urandom), ordy, 1'b0, 8'($urandom), acc);
    end
    check_val("frame_done_seen", 32'(done_seen), 32'(1));
    check_val("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, acc);
    check_val("idle_busy", 32'(busy), 32'(0));
  endtask

  task automatic check_ff_sequence(input string tag);
    check_val({tag, "_seq0"}, 32'(out_log[0]), 32'(8'hFE));
    check_val({tag, "_seq1"}, 32'(out_log[1]), 32'(8'hFC));
    check_val({tag, "_seq2"}, 32'(out_log[2]), 32'(8'hFE));
    check_val({tag, "_wrap255"}, 32'(out_log[255]), 32'(8'hFE));
    check_val({tag, "_wrap256"}, 32'(out_log[256]), 32'(8'hFC));
  endtask

  task automatic reset_mid_frame();
    logic acc;
    done_seen = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h33, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h33, acc);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, acc);
    check_val("pre_reset_accept", 32'(acc), 32'(1));
    @(negedge clk);
    pif.in_valid = 1'b0;
    check_val("pre_reset_out_valid", 32'(pif.out_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", 32'(pif.out_valid), 32'(0));
    check_val("rst_out_data", 32'(pif.out_data), 32'(0));
    check_val("rst_in_ready", 32'(pif.in_ready), 32'(0));
    check_val("rst_busy", 32'(busy), 32'(0));
    check_val("rst_done", 32'(done), 32'(0));
    exp_q.delete();
    out_cnt     = 0;
    expect_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0, 8'($urandom), acc);
      check_val("post_reset_in_ready", 32'(pif.in_ready), 32'(0));
      check_val("post_reset_busy", 32'(busy), 32'(0));
    end
    check_val("post_reset_no_done", 32'(done_seen), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    key           = 8'h00;
    pif.in_valid  = 1'b0;
    pif.in_data   = '0;
    pif.out_ready = 1'b0;
    #12;
    check_val("reset_out_valid", 32'(pif.out_valid), 32'(0));
    check_val("reset_out_data", 32'(pif.out_data), 32'(0));
    check_val("reset_in_ready", 32'(pif.in_ready), 32'(0));
    check_val("reset_busy", 32'(busy), 32'(0));
    check_val("reset_done", 32'(done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] frame 1: key 6A, all-FF pixels, full flow");
    run_frame(8'h6A, 8'hFF, 100, 100, 1'b0, 1'b0);
    check_ff_sequence("f1");

    $display("[TB] frame 2: key 6A again with gaps, stall and start pulse mid-run");
    run_frame(8'h6A, 8'hFF, 50, 60, 1'b1, 1'b1);
    check_ff_sequence("f2");

    $display("[TB] frame 3: zero key");
    run_frame(8'h00, 8'h00, 70, 80, 1'b0, 1'b0);
    check_val("zero_key_first", 32'(out_log[0]), 32'(8'h02));

    $display("[TB] frame 4: random key and pixels");
    run_frame(8'($urandom_range(255, 1)), -1, 60, 50, 1'b1, 1'b1);

    $display("[TB] mid-frame reset");
    reset_mid_frame();

    $display("[TB] frame 5: random frame after reset");
    run_frame(8'($urandom), -1, 80, 70, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
